// File: rtl/axis_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_out_pkg
//  Description : Shared types and helpers for the AXI-Stream output packer:
//                FSM state encoding, pixel/byte derivations and the edge
//                keep-mask generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_out_pkg;

    // Upper bound on keep-vector width; edge_mask returns this many bits and
    // callers cast down to their own DATA_WIDTH/8.
    localparam int c_MAX_KEEP = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Pixels per beat.
    function automatic int ppb(input int data_width, input int pix_bits);
        return data_width / pix_bits;
    endfunction

    // Bytes per pixel.
    function automatic int bpp(input int pix_bits);
        return pix_bits / 8;
    endfunction

    // Keep vector for one beat: lanes below keep_bytes are set, then the low
    // edge lanes are cleared on the first beat of a frame and the high edge
    // lanes on the last beat. A single-beat frame gets both masks.
    function automatic logic [c_MAX_KEEP-1:0] edge_mask(
        input int   keep_bytes,
        input int   edge_bytes,
        input logic first,
        input logic last
    );
        logic [c_MAX_KEEP-1:0] m;
        m = '0;
        for (int i = 0; i < c_MAX_KEEP; i++) begin
            if (i < keep_bytes) begin
                m[i] = 1'b1;
                if (first && (i < edge_bytes))              m[i] = 1'b0;
                if (last  && (i >= keep_bytes - edge_bytes)) m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : out_fifo
//  Description : Synchronous FIFO with a registered read port. Pointers carry
//                an extra wrap bit so full/empty are told apart without a
//                separate counter. A flush clears both pointers.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                i_flush             - drop all contents
//                i_wr_en/i_wr_data   - write request (ignored when full)
//                i_rd_en             - load next entry into o_rd_data
//                                      (ignored when empty)
//                o_full/o_empty      - status
//                o_level             - occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module out_fifo #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;

    assign w_wr = i_wr_en & ~o_full;
    assign w_rd = i_rd_en & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            o_rd_data <= '0;
        end else if (i_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                o_rd_data <= r_mem[r_rd_ptr[c_AW-1:0]];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_out_packer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_out_packer
//  Description : Buffers Up-Sampling write beats in a FIFO and emits them as
//                an AXI-Stream with per-row tlast, start-of-frame tuser and
//                edge-pixel masking on tkeep/tstrb.
//  Ports       : clk, rst                 - clock, synchronous active-high rst
//                cfg_width, cfg_height    - frame size (pixels, rows)
//                start, abort             - frame control
//                busy, frame_done, cfg_err- status
//                ofifo_level              - FIFO occupancy
//                upsp_ac_w*, ac_upsp_wready - write side
//                m_axis_*                 - AXI-Stream master
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_out_packer #(
    parameter int DATA_WIDTH = 96,
    parameter int PIX_BITS   = 24,
    parameter int FIFO_DEPTH = 128,
    parameter int DIM_WIDTH  = 13,
    parameter int EDGE_PIX   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIM_WIDTH-1:0]          cfg_width,
    input  logic [DIM_WIDTH-1:0]          cfg_height,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          cfg_err,
    output logic [$clog2(FIFO_DEPTH):0]   ofifo_level,
    input  logic                          upsp_ac_wvalid,
    input  logic [DATA_WIDTH-1:0]         upsp_ac_wdata,
    output logic                          ac_upsp_wready,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
    output logic [DATA_WIDTH/8-1:0]       m_axis_tstrb,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser
);

    import axis_out_pkg::*;

    localparam int c_PPB    = ppb(DATA_WIDTH, PIX_BITS);
    localparam int c_BPP    = bpp(PIX_BITS);
    localparam int c_KEEP_W = DATA_WIDTH / 8;
    localparam int c_TW     = 2 * DIM_WIDTH;
    localparam logic [DIM_WIDTH-1:0] c_PPB_D = DIM_WIDTH'(c_PPB);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_cfg_err;
    logic [DIM_WIDTH-1:0]    r_bpr;
    logic [c_TW-1:0]         r_total;
    logic [c_TW-1:0]         r_wr_acc;
    logic [c_TW-1:0]         r_beat;
    logic [DIM_WIDTH-1:0]    r_col;
    logic                    r_tvalid;
    logic [c_KEEP_W-1:0]     r_tkeep;
    logic                    r_tlast;
    logic                    r_tuser;

    logic                    w_cfg_bad;
    logic                    w_start_ok;
    logic                    w_start_bad;
    logic [DIM_WIDTH-1:0]    w_bpr;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_hs;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_col_wrap;
    logic [DIM_WIDTH-1:0]    w_col_inc;
    logic [c_TW-1:0]         w_beat_inc;
    logic [DIM_WIDTH-1:0]    w_ld_col;
    logic [c_TW-1:0]         w_ld_beat;
    logic [c_KEEP_W-1:0]     w_ld_keep;

    // ---------------- start qualification ----------------
    assign w_cfg_bad   = (cfg_width == '0) || (cfg_height == '0) ||
                         ((cfg_width % c_PPB_D) != '0);
    assign w_start_ok  = start & ~abort & (r_state == IDLE) & ~w_cfg_bad;
    assign w_start_bad = start & ~abort & (r_state == IDLE) &  w_cfg_bad;
    assign w_bpr       = cfg_width / c_PPB_D;

    // ---------------- handshakes ----------------
    assign ac_upsp_wready = (r_state == RUN) & ~w_full & (r_wr_acc < r_total);
    assign w_wr = upsp_ac_wvalid & ac_upsp_wready;
    assign w_hs = r_tvalid & m_axis_tready;
    // The output register refills whenever it is empty or draining this cycle.
    assign w_rd = ~w_empty & (~r_tvalid | m_axis_tready) & ~abort;

    // ---------------- position of the beat being loaded ----------------
    // Handshake counters point at the beat currently on the bus; if it leaves
    // this cycle the beat entering the register is the one after it.
    assign w_col_wrap = (r_col == r_bpr - DIM_WIDTH'(1));
    assign w_col_inc  = w_col_wrap ? '0 : r_col + DIM_WIDTH'(1);
    assign w_beat_inc = r_beat + c_TW'(1);
    assign w_ld_col   = w_hs ? w_col_inc  : r_col;
    assign w_ld_beat  = w_hs ? w_beat_inc : r_beat;
    assign w_ld_keep  = c_KEEP_W'(edge_mask(c_KEEP_W, EDGE_PIX * c_BPP,
                                            w_ld_beat == '0,
                                            w_ld_beat == r_total - c_TW'(1)));

    out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (abort),
        .i_wr_en   (w_wr),
        .i_wr_data (upsp_ac_wdata),
        .i_rd_en   (w_rd),
        .o_rd_data (m_axis_tdata),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (ofifo_level)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) w_state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (abort)                                  w_state_nxt = IDLE;
                else if (w_hs && (w_beat_inc == r_total))   w_state_nxt = DONE;
            end
            DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- counters and output register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
            r_bpr     <= '0;
            r_total   <= '0;
            r_wr_acc  <= '0;
            r_beat    <= '0;
            r_col     <= '0;
            r_tvalid  <= 1'b0;
            r_tkeep   <= '1;
            r_tlast   <= 1'b0;
            r_tuser   <= 1'b0;
        end else begin
            r_cfg_err <= w_start_bad;

            if (w_start_ok) begin
                r_bpr    <= w_bpr;
                r_total  <= c_TW'(w_bpr) * c_TW'(cfg_height);
                r_wr_acc <= '0;
                r_beat   <= '0;
                r_col    <= '0;
            end else if (abort) begin
                r_wr_acc <= '0;
                r_beat   <= '0;
                r_col    <= '0;
            end else begin
                if (w_wr) r_wr_acc <= r_wr_acc + c_TW'(1);
                if (w_hs) begin
                    r_beat <= w_beat_inc;
                    r_col  <= w_col_inc;
                end
            end

            if (abort) begin
                r_tvalid <= 1'b0;
            end else if (w_rd) begin
                r_tvalid <= 1'b1;
                r_tkeep  <= w_ld_keep;
                r_tlast  <= (w_ld_col == r_bpr - DIM_WIDTH'(1));
                r_tuser  <= (w_ld_beat == '0);
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign cfg_err       = r_cfg_err;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tstrb  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;

endmodule
`default_nettype wire

// File: tb/tb_axis_out_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_out_packer
//  Description : Directed self-checking bench for axis_out_packer (default
//                parameters: 96-bit data, 4 pixels/beat, 12 keep lanes,
//                6 edge lanes, 128-entry FIFO).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_out_packer;

    localparam int DW = 96;
    localparam int KW = 12;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [12:0]   cfg_width, cfg_height;
    logic          start, abort;
    logic          busy, frame_done, cfg_err;
    logic [LW-1:0] ofifo_level;
    logic          upsp_ac_wvalid;
    logic [DW-1:0] upsp_ac_wdata;
    logic          ac_upsp_wready;
    logic          m_axis_tvalid, m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep, m_axis_tstrb;
    logic          m_axis_tlast, m_axis_tuser;

    always #5 clk = ~clk;

    axis_out_packer dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .frame_done     (frame_done),
        .cfg_err        (cfg_err),
        .ofifo_level    (ofifo_level),
        .upsp_ac_wvalid (upsp_ac_wvalid),
        .upsp_ac_wdata  (upsp_ac_wdata),
        .ac_upsp_wready (ac_upsp_wready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tstrb   (m_axis_tstrb),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser)
    );

    int n_vec = 0;
    int n_mis = 0;
    int wseq = 0;
    int fwr = 0;
    int wr_limit = 1000000;
    int n_done = 0;
    int n_err = 0;
    bit rnd_w = 0;
    bit rnd_r = 0;
    bit rdy = 0;
    int base;

    logic [DW-1:0] cap_d [$];
    logic [KW-1:0] cap_k [$];
    logic [KW-1:0] cap_s [$];
    logic          cap_l [$];
    logic          cap_u [$];

    function automatic logic [DW-1:0] pat(input int s);
        logic [31:0] u;
        u = s;
        return {32'hC0DE_0000 + u, 32'h1234_0000 ^ u, ~u};
    endfunction

    function automatic logic [KW-1:0] exp_keep(input int k, input int total);
        logic [KW-1:0] m;
        m = 12'hFFF;
        if (k == 0)         m = m & 12'hFC0;
        if (k == total - 1) m = m & 12'h03F;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        assert (act === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: record handshakes and pulses at the falling edge, then
    // update the drivers just after the rising edge.
    task automatic step();
        @(negedge clk);
        if (upsp_ac_wvalid && ac_upsp_wready) begin
            wseq++;
            fwr++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            cap_d.push_back(m_axis_tdata);
            cap_k.push_back(m_axis_tkeep);
            cap_s.push_back(m_axis_tstrb);
            cap_l.push_back(m_axis_tlast);
            cap_u.push_back(m_axis_tuser);
        end
        if (frame_done) n_done++;
        if (cfg_err)    n_err++;
        @(posedge clk);
        #1;
        upsp_ac_wvalid = (fwr < wr_limit) && (!rnd_w || ($urandom_range(0, 1) == 1));
        upsp_ac_wdata  = pat(wseq);
        m_axis_tready  = rnd_r ? ($urandom_range(0, 1) == 1) : rdy;
    endtask

    task automatic begin_frame(input int w, input int h, output int b);
        cfg_width  = 13'(w);
        cfg_height = 13'(h);
        b      = wseq;
        fwr    = 0;
        n_done = 0;
        cap_d.delete(); cap_k.delete(); cap_s.delete(); cap_l.delete(); cap_u.delete();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_done(input string tag, input int budget);
        int n;
        n = 0;
        while (n_done == 0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, ".done_seen"}, 128'(n_done != 0), 128'd1);
    endtask

    task automatic check_frame(input string tag, input int nb, input int bpr, input int b);
        chk({tag, ".beats"}, 128'(cap_d.size()), 128'(nb));
        for (int k = 0; k < cap_d.size() && k < nb; k++) begin
            chk($sformatf("%s.data%0d", tag, k), 128'(cap_d[k]), 128'(pat(b + k)));
            chk($sformatf("%s.keep%0d", tag, k), 128'(cap_k[k]), 128'(exp_keep(k, nb)));
            chk($sformatf("%s.strb%0d", tag, k), 128'(cap_s[k]), 128'(exp_keep(k, nb)));
            chk($sformatf("%s.last%0d", tag, k), 128'(cap_l[k]), 128'((k % bpr) == bpr - 1));
            chk($sformatf("%s.user%0d", tag, k), 128'(cap_u[k]), 128'(k == 0));
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_width = '0; cfg_height = '0;
        upsp_ac_wvalid = 1'b0; upsp_ac_wdata = '0; m_axis_tready = 1'b0;

        // ---- reset state ----
        step(); step();
        chk("rst.tvalid", 128'(m_axis_tvalid), 128'd0);
        chk("rst.tkeep",  128'(m_axis_tkeep),  128'hFFF);
        chk("rst.tstrb",  128'(m_axis_tstrb),  128'hFFF);
        chk("rst.tlast",  128'(m_axis_tlast),  128'd0);
        chk("rst.tuser",  128'(m_axis_tuser),  128'd0);
        chk("rst.tdata",  128'(m_axis_tdata),  128'd0);
        chk("rst.busy",   128'(busy),          128'd0);
        chk("rst.level",  128'(ofifo_level),   128'd0);
        chk("rst.wready", 128'(ac_upsp_wready), 128'd0);
        chk("rst.cfgerr", 128'(cfg_err),       128'd0);
        rst = 1'b0;
        step();

        // ---- 8x2 frame, continuous flow ----
        rdy = 1'b1; m_axis_tready = 1'b1;
        begin_frame(8, 2, base);
        chk("f8x2.busy", 128'(busy), 128'd1);
        run_done("f8x2", 100);
        step(); step();
        chk("f8x2.done_cnt", 128'(n_done), 128'd1);
        chk("f8x2.busy_end", 128'(busy), 128'd0);
        check_frame("f8x2", 4, 2, base);

        // ---- back-pressure, 4096x1 ----
        rdy = 1'b0; m_axis_tready = 1'b0;
        begin_frame(4096, 1, base);
        for (int i = 0; i < 200; i++) begin
            step();
            if (i == 5) chk("bp.tdata_early", 128'(m_axis_tdata), 128'(pat(base)));
        end
        chk("bp.level",  128'(ofifo_level),    128'd128);
        chk("bp.wready", 128'(ac_upsp_wready), 128'd0);
        chk("bp.tvalid", 128'(m_axis_tvalid),  128'd1);
        chk("bp.tdata",  128'(m_axis_tdata),   128'(pat(base)));
        chk("bp.tkeep",  128'(m_axis_tkeep),   128'hFC0);
        chk("bp.tuser",  128'(m_axis_tuser),   128'd1);
        rdy = 1'b1; m_axis_tready = 1'b1;
        n = 0;
        while (n_done == 0 && n < 3000) begin
            step();
            n++;
            if (n == 10) chk("bp.level_rw", 128'(ofifo_level), 128'd127);
        end
        chk("bp.cycles", 128'(n), 128'd1025);
        check_frame("bp", 1024, 1024, base);

        // ---- configuration errors ----
        n_err = 0;
        cfg_width = 13'd6; cfg_height = 13'd1; start = 1'b1;
        step(); start = 1'b0;
        chk("err6.pulse", 128'(cfg_err), 128'd1);
        chk("err6.busy",  128'(busy),    128'd0);
        step();
        chk("err6.clear", 128'(cfg_err), 128'd0);
        cfg_width = 13'd0; start = 1'b1;
        step(); start = 1'b0;
        chk("err0.pulse", 128'(cfg_err), 128'd1);
        chk("err0.busy",  128'(busy),    128'd0);
        step();
        chk("err.count", 128'(n_err), 128'd2);

        // ---- write limit, 4x1 (single beat, both edge masks) ----
        begin_frame(4, 1, base);
        chk("wl.busy", 128'(busy), 128'd1);
        step();
        chk("wl.wready_run", 128'(ac_upsp_wready), 128'd0);
        chk("wl.busy_run",   128'(busy),           128'd1);
        run_done("wl", 50);
        for (int i = 0; i < 5; i++) step();
        chk("wl.writes", 128'(fwr), 128'd1);
        check_frame("wl", 1, 1, base);

        // ---- abort with 10 entries queued ----
        rdy = 1'b0; m_axis_tready = 1'b0; wr_limit = 11;
        begin_frame(64, 1, base);
        for (int i = 0; i < 20; i++) step();
        chk("ab.level_pre", 128'(ofifo_level),   128'd10);
        chk("ab.tvalid_pre", 128'(m_axis_tvalid), 128'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab.tvalid", 128'(m_axis_tvalid), 128'd0);
        chk("ab.level",  128'(ofifo_level),   128'd0);
        chk("ab.busy",   128'(busy),          128'd0);
        wr_limit = 1000000; rdy = 1'b1; m_axis_tready = 1'b1;
        step();
        begin_frame(8, 1, base);
        run_done("ab8", 100);
        check_frame("ab8", 2, 2, base);

        // ---- reset during RUN ----
        rdy = 1'b0; m_axis_tready = 1'b0;
        begin_frame(64, 1, base);
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        chk("rr.tvalid", 128'(m_axis_tvalid),  128'd0);
        chk("rr.level",  128'(ofifo_level),    128'd0);
        chk("rr.busy",   128'(busy),           128'd0);
        chk("rr.wready", 128'(ac_upsp_wready), 128'd0);
        chk("rr.tkeep",  128'(m_axis_tkeep),   128'hFFF);
        chk("rr.tdata",  128'(m_axis_tdata),   128'd0);
        chk("rr.tuser",  128'(m_axis_tuser),   128'd0);
        rst = 1'b0;
        step();

        // ---- random ready / valid, 16x3 ----
        rnd_r = 1'b1; rnd_w = 1'b1;
        begin_frame(16, 3, base);
        run_done("rnd", 2000);
        step(); step();
        chk("rnd.done_cnt", 128'(n_done), 128'd1);
        check_frame("rnd", 12, 4, base);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
